tx_intf_acc_reader: RTL

Downstream consumer of the dual-queue TX DMA FIFO stage. On a start command it selects one queue and pulls exactly one packet's worth of 64-bit words through the EMPTYN_TO_ACC / ACC_ASK_DATA read interface. It re-times those words into a valid/ready stream, with last-word marking, for the bit/encoder stage. It also handles FIFO underrun timeout and abort.

---
 rtl/tx_intf_acc_reader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tx_intf_acc_reader.sv
// Pulls one packet from the selected TX DMA queue into a 2-entry skid buffer feeding a registered valid/ready stream.
// First word valid two edges after start is sampled; reads are only issued when the buffer can absorb them, so backpressure never loses a word.
module tx_intf_acc_reader #(
    parameter int C_S_AXIS_TDATA_WIDTH   = 64,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int TIMEOUT_BITS           = 10,
    parameter int UNDERRUN_TIMEOUT       = 1023
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              start,
    input  logic [1:0]                        queue_idx_in,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_word,
    input  logic                              abort,
    output logic [1:0]                        tx_queue_idx,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   DATA_TO_ACC,
    input  logic                              EMPTYN_TO_ACC,
    output logic                              ACC_ASK_DATA,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   tx_data,
    output logic                              tx_data_valid,
    output logic                              tx_data_last,
    input  logic                              tx_data_ready,
    output logic                              busy,
    output logic                              pkt_done,
    output logic                              underrun,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] word_count
);

    localparam int DW = C_S_AXIS_TDATA_WIDTH;
    localparam int NW = MAX_BIT_NUM_DMA_SYMBOL;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_BITS'(UNDERRUN_TIMEOUT - 1);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } word_t;

    logic [1:0]              state;
    logic [NW-1:0]           num_word_r;
    logic [NW:0]             reads_issued;
    logic [TIMEOUT_BITS-1:0] timer;
    logic                    infl_vld;
    logic                    infl_last;
    logic                    underrun_r;
    word_t                   head;
    word_t                   skid;
    logic                    head_vld;
    logic                    skid_vld;

    logic       pop;
    logic [1:0] occ_after;
    logic [1:0] held;
    logic       rd_ok;
    logic       last_read;
    logic       ask;
    logic       abort_hit;
    logic       under_hit;
    logic       flush;
    word_t      word_in;
    logic       unused_qidx_hi;

    assign unused_qidx_hi = queue_idx_in[1];

    // Occupancy is counted after this cycle's pop so a steady stream keeps one read in flight every cycle.
    assign pop       = head_vld && tx_data_ready;
    assign occ_after = {1'b0, head_vld} + {1'b0, skid_vld} - {1'b0, pop};
    assign held      = occ_after + {1'b0, infl_vld};
    assign rd_ok     = reads_issued <= {1'b0, num_word_r};
    assign last_read = reads_issued == {1'b0, num_word_r};
    assign ask       = (state == ST_READ) && EMPTYN_TO_ACC && rd_ok && (held < 2'd2);
    assign abort_hit = abort && ((state == ST_READ) || (state == ST_DRAIN));
    assign under_hit = (state == ST_READ) && !EMPTYN_TO_ACC && (timer == TMO_LAST);
    assign flush     = abort_hit || under_hit;
    assign word_in   = '{last: infl_last, dat: DATA_TO_ACC};

    assign ACC_ASK_DATA  = ask;
    assign tx_data       = head.dat;
    assign tx_data_last  = head.last;
    assign tx_data_valid = head_vld;
    assign busy          = state != ST_IDLE;
    assign pkt_done      = state == ST_DONE;
    assign underrun      = underrun_r;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state        <= ST_IDLE;
            num_word_r   <= '0;
            reads_issued <= '0;
            timer        <= '0;
            infl_vld     <= 1'b0;
            infl_last    <= 1'b0;
            underrun_r   <= 1'b0;
            tx_queue_idx <= 2'b00;
            word_count   <= '0;
        end else begin
            underrun_r <= 1'b0;
            infl_vld   <= ask && !abort_hit;
            infl_last  <= last_read;
            if (pop) begin
                word_count <= word_count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_word_r   <= num_word;
                        tx_queue_idx <= {1'b0, queue_idx_in[0]};
                        reads_issued <= '0;
                        timer        <= '0;
                        word_count   <= '0;
                        state        <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (abort_hit) begin
                        state <= ST_IDLE;
                    end else if (under_hit) begin
                        underrun_r <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        if (ask) begin
                            reads_issued <= reads_issued + 1'b1;
                            if (last_read) begin
                                state <= ST_DRAIN;
                            end
                        end
                        if (ask || EMPTYN_TO_ACC) begin
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort_hit) begin
                        state <= ST_IDLE;
                    end else if (pop && head.last) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Skid buffer: head drives the output registers, skid catches the read that was in flight when the head stalled.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            head     <= '0;
            skid     <= '0;
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            head     <= '0;
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (pop) begin
            if (skid_vld) begin
                head     <= skid;
                skid_vld <= infl_vld;
                if (infl_vld) begin
                    skid <= word_in;
                end
            end else begin
                head_vld <= infl_vld;
                if (infl_vld) begin
                    head <= word_in;
                end
            end
        end else if (infl_vld) begin
            if (!head_vld) begin
                head_vld <= 1'b1;
                head     <= word_in;
            end else begin
                skid_vld <= 1'b1;
                skid     <= word_in;
            end
        end
    end

endmodule
